// File: rtl/tag_mem_pkg.sv
// Shared types and constants for the tag memory / serialiser slice.
// Holds bank codes, FSM states, SELECT action codes, the READ header bit,
// the latched reply context and the SL flag update rule.
package tag_mem_pkg;

  typedef enum logic [1:0] {
    BANK_RESERVED = 2'd0,
    BANK_EPC      = 2'd1,
    BANK_TID      = 2'd2,
    BANK_USER     = 2'd3
  } bank_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR    = 3'd1,
    ST_DATA   = 3'd2,
    ST_HANDLE = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Gen2 SELECT actions, named as <on match>_<on no match>
  typedef enum logic [2:0] {
    SEL_SET_CLR    = 3'd0,
    SEL_SET_NOP    = 3'd1,
    SEL_NOP_CLR    = 3'd2,
    SEL_TOG_NOP    = 3'd3,
    SEL_CLR_SET    = 3'd4,
    SEL_CLR_NOP    = 3'd5,
    SEL_NOP_SET    = 3'd6,
    SEL_NOP_TOG    = 3'd7
  } sel_action_e;

  // Leading bit of a READ reply
  localparam logic READ_HDR_BIT = 1'b0;

  // Reply parameters captured on start
  typedef struct packed {
    logic       mode;
    logic [1:0] bank;
    logic [7:0] ptr;
    logic [7:0] words;
  } reply_ctx_t;

  // Next SL flag value for a SELECT action and compare result
  function automatic logic sl_next(input logic [2:0] action, input logic match,
                                   input logic cur);
    logic nxt;
    nxt = cur;
    case (action)
      SEL_SET_CLR: nxt = match ? 1'b1 : 1'b0;
      SEL_SET_NOP: nxt = match ? 1'b1 : cur;
      SEL_NOP_CLR: nxt = match ? cur  : 1'b0;
      SEL_TOG_NOP: nxt = match ? ~cur : cur;
      SEL_CLR_SET: nxt = match ? 1'b0 : 1'b1;
      SEL_CLR_NOP: nxt = match ? 1'b0 : cur;
      SEL_NOP_SET: nxt = match ? cur  : 1'b1;
      SEL_NOP_TOG: nxt = match ? cur  : ~cur;
      default:     nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/tag_mem_array.sv
// Four-bank tag word memory (4 x WORDS_PER_BANK x 16).
// Ports: clk/reset (sync, active-high, reloads init contents),
//   wr_*  : synchronous write port, out-of-range pointers ignored,
//   rd_*  : combinational read port for the serialiser,
//   sel_* : combinational read port for the SELECT compare.
// Out-of-range read pointers return 16'h0000.
module tag_mem_array
  import tag_mem_pkg::*;
#(
  parameter int unsigned WORDS_PER_BANK = 8,
  parameter int unsigned EPC_WORDS      = 7,
  parameter logic [16*EPC_WORDS-1:0] EPC_INIT = '0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [1:0]  wr_bank,
  input  logic [7:0]  wr_ptr,
  input  logic [15:0] wr_data,
  input  logic [1:0]  rd_bank,
  input  logic [7:0]  rd_ptr,
  output logic [15:0] rd_data,
  input  logic [1:0]  sel_bank,
  input  logic [7:0]  sel_ptr,
  output logic [15:0] sel_data
);

  localparam int unsigned AW = $clog2(WORDS_PER_BANK);

  logic [15:0] mem_q [4][WORDS_PER_BANK];
  logic [15:0] mem_d [4][WORDS_PER_BANK];

  // Bank 1 words 1..EPC_WORDS hold EPC_INIT, MSB word first; all else zero
  function automatic logic [15:0] init_word(input int unsigned b, input int unsigned w);
    if (b == 32'(BANK_EPC) && w >= 1 && w <= EPC_WORDS)
      return EPC_INIT[16*(EPC_WORDS-w) +: 16];
    return 16'h0000;
  endfunction

  // Write port
  always_comb begin
    mem_d = mem_q;
    if (wr_en && (wr_ptr < 8'(WORDS_PER_BANK)))
      mem_d[wr_bank][wr_ptr[AW-1:0]] = wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < 4; b++)
        for (int w = 0; w < int'(WORDS_PER_BANK); w++)
          mem_q[b][w] <= init_word(32'(b), 32'(w));
    end else begin
      mem_q <= mem_d;
    end
  end

  // Read ports
  always_comb begin
    rd_data  = (rd_ptr  < 8'(WORDS_PER_BANK)) ? mem_q[rd_bank][rd_ptr[AW-1:0]]   : 16'h0000;
    sel_data = (sel_ptr < 8'(WORDS_PER_BANK)) ? mem_q[sel_bank][sel_ptr[AW-1:0]] : 16'h0000;
  end

endmodule

// File: rtl/tag_memory_serializer.sv
// Tag memory plus bit-serial reply source.
// Serves EPC replies (mode 0) and READ replies (mode 1: header bit, data
// words, handle) one bit per membitclk rising edge, MSB first. Also commits
// WRITE words on epc_data_ready rising edges and evaluates SELECT into sl_flag.
// Inputs : clk, reset, start, mode, readwritebank, readwriteptr, readwords,
//          currenthandle, membitclk, writedataout, epc_data_ready,
//          sel_strobe, sel_action, sel_ptr, mask.
// Outputs: membitsrc, memdatadone, sl_flag, busy (all registered).
module tag_memory_serializer
  import tag_mem_pkg::*;
#(
  parameter int unsigned WORDS_PER_BANK = 8,
  parameter int unsigned EPC_WORDS      = 7,
  parameter logic [16*EPC_WORDS-1:0] EPC_INIT = 112'h3000_0000_0000_0000_0000_0000_1234
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        mode,
  input  logic [1:0]  readwritebank,
  input  logic [7:0]  readwriteptr,
  input  logic [7:0]  readwords,
  input  logic [15:0] currenthandle,
  input  logic        membitclk,
  output logic        membitsrc,
  output logic        memdatadone,
  input  logic [15:0] writedataout,
  input  logic        epc_data_ready,
  input  logic        sel_strobe,
  input  logic [2:0]  sel_action,
  input  logic [7:0]  sel_ptr,
  input  logic [15:0] mask,
  output logic        sl_flag,
  output logic        busy
);

  state_e     state_q, state_d;
  reply_ctx_t ctx_q, ctx_d;
  logic [15:0] shreg_q, shreg_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic        mbc_q, edr_q;
  logic        membitsrc_q, membitsrc_d;
  logic        memdatadone_q, memdatadone_d;
  logic        busy_q, busy_d;
  logic        sl_flag_q, sl_flag_d;

  logic        bit_edge_c, wr_fire_c, sel_match_c;
  reply_ctx_t  start_ctx_c;
  logic [1:0]  rd_bank_c;
  logic [7:0]  rd_ptr_c;
  logic [15:0] rd_mem_c, rd_word_c, sel_data_c;

  assign bit_edge_c = membitclk & ~mbc_q;
  assign wr_fire_c  = epc_data_ready & ~edr_q;

  tag_mem_array #(
    .WORDS_PER_BANK (WORDS_PER_BANK),
    .EPC_WORDS      (EPC_WORDS),
    .EPC_INIT       (EPC_INIT)
  ) u_array (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_fire_c),
    .wr_bank  (readwritebank),
    .wr_ptr   (readwriteptr),
    .wr_data  (writedataout),
    .rd_bank  (rd_bank_c),
    .rd_ptr   (rd_ptr_c),
    .rd_data  (rd_mem_c),
    .sel_bank (readwritebank),
    .sel_ptr  (sel_ptr),
    .sel_data (sel_data_c)
  );

  // Reply context captured on start; readwords of 0 means one word
  always_comb begin
    start_ctx_c.mode  = mode;
    start_ctx_c.bank  = mode ? readwritebank : BANK_EPC;
    start_ctx_c.ptr   = mode ? readwriteptr : 8'd1;
    start_ctx_c.words = mode ? ((readwords == 8'd0) ? 8'd1 : readwords) : 8'(EPC_WORDS);
  end

  // Word to load next: the first word on start, otherwise pointer+1
  always_comb begin
    rd_bank_c = start ? start_ctx_c.bank : ctx_q.bank;
    rd_ptr_c  = start ? start_ctx_c.ptr  : ctx_q.ptr + 8'd1;
  end

  // A write landing this cycle on the word being loaded wins over the array
  always_comb begin
    rd_word_c = rd_mem_c;
    if (wr_fire_c && (readwritebank == rd_bank_c) && (readwriteptr == rd_ptr_c) &&
        (readwriteptr < 8'(WORDS_PER_BANK)))
      rd_word_c = writedataout;
  end

  assign sel_match_c = (sel_ptr < 8'(WORDS_PER_BANK)) && (sel_data_c == mask);

  // Serialiser next state and registered-output next values
  always_comb begin
    state_d   = state_q;
    ctx_d     = ctx_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;

    case (state_q)
      ST_HDR: begin
        if (bit_edge_c) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_edge_c) begin
          shreg_d   = {shreg_q[14:0], 1'b0};
          bit_cnt_d = bit_cnt_q - 4'd1;
          if (bit_cnt_q == 4'd0) begin
            bit_cnt_d = 4'd15;
            if (ctx_q.words > 8'd1) begin
              shreg_d     = rd_word_c;
              ctx_d.ptr   = ctx_q.ptr + 8'd1;
              ctx_d.words = ctx_q.words - 8'd1;
            end else if (ctx_q.mode) begin
              shreg_d = currenthandle;
              state_d = ST_HANDLE;
            end else begin
              state_d = ST_DONE;
            end
          end
        end
      end
      ST_HANDLE: begin
        if (bit_edge_c) begin
          shreg_d   = {shreg_q[14:0], 1'b0};
          bit_cnt_d = bit_cnt_q - 4'd1;
          if (bit_cnt_q == 4'd0) state_d = ST_DONE;
        end
      end
      default: ;
    endcase

    // start preempts any reply in progress
    if (start) begin
      ctx_d     = start_ctx_c;
      shreg_d   = rd_word_c;
      bit_cnt_d = 4'd15;
      state_d   = mode ? ST_HDR : ST_DATA;
    end

    membitsrc_d = 1'b0;
    if (state_d == ST_HDR)
      membitsrc_d = READ_HDR_BIT;
    else if (state_d == ST_DATA || state_d == ST_HANDLE)
      membitsrc_d = shreg_d[15];
    memdatadone_d = (state_d == ST_DONE);
    busy_d        = (state_d == ST_HDR) || (state_d == ST_DATA) || (state_d == ST_HANDLE);

    sl_flag_d = sel_strobe ? sl_next(sel_action, sel_match_c, sl_flag_q) : sl_flag_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      ctx_q         <= '0;
      shreg_q       <= 16'h0000;
      bit_cnt_q     <= 4'd0;
      mbc_q         <= 1'b0;
      edr_q         <= 1'b0;
      membitsrc_q   <= 1'b0;
      memdatadone_q <= 1'b0;
      busy_q        <= 1'b0;
      sl_flag_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ctx_q         <= ctx_d;
      shreg_q       <= shreg_d;
      bit_cnt_q     <= bit_cnt_d;
      mbc_q         <= membitclk;
      edr_q         <= epc_data_ready;
      membitsrc_q   <= membitsrc_d;
      memdatadone_q <= memdatadone_d;
      busy_q        <= busy_d;
      sl_flag_q     <= sl_flag_d;
    end
  end

  assign membitsrc   = membitsrc_q;
  assign memdatadone = memdatadone_q;
  assign busy        = busy_q;
  assign sl_flag     = sl_flag_q;

endmodule

// File: tb/tb_tag_memory_serializer.sv
// Directed self-checking bench for tag_memory_serializer.
module tb_tag_memory_serializer;

  localparam logic [111:0] EPC_INIT = 112'h3000_0000_0000_0000_0000_0000_1234;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [1:0]  readwritebank = 2'd0;
  logic [7:0]  readwriteptr = 8'd0;
  logic [7:0]  readwords = 8'd0;
  logic [15:0] currenthandle = 16'h0000;
  logic        membitclk = 1'b0;
  logic        membitsrc;
  logic        memdatadone;
  logic [15:0] writedataout = 16'h0000;
  logic        epc_data_ready = 1'b0;
  logic        sel_strobe = 1'b0;
  logic [2:0]  sel_action = 3'd0;
  logic [7:0]  sel_ptr = 8'd0;
  logic [15:0] mask = 16'h0000;
  logic        sl_flag;
  logic        busy;

  int total = 0;
  int bad   = 0;

  tag_memory_serializer dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .mode           (mode),
    .readwritebank  (readwritebank),
    .readwriteptr   (readwriteptr),
    .readwords      (readwords),
    .currenthandle  (currenthandle),
    .membitclk      (membitclk),
    .membitsrc      (membitsrc),
    .memdatadone    (memdatadone),
    .writedataout   (writedataout),
    .epc_data_ready (epc_data_ready),
    .sel_strobe     (sel_strobe),
    .sel_action     (sel_action),
    .sel_ptr        (sel_ptr),
    .mask           (mask),
    .sl_flag        (sl_flag),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Collect n bits, one per membitclk rising edge; report whether memdatadone
  // was seen before the final edge and whether it was set one clk after it.
  task automatic run_bits(input int n, output logic [159:0] s,
                          output logic done_early, output logic done_after);
    s = '0;
    done_early = 1'b0;
    done_after = 1'b0;
    for (int i = 0; i < n; i++) begin
      s = {s[158:0], membitsrc};
      done_early = done_early | memdatadone;
      membitclk = 1'b1;
      tick();
      if (i == n - 1) done_after = memdatadone;
      else            done_early = done_early | memdatadone;
      membitclk = 1'b0;
      tick();
    end
  endtask

  task automatic do_write(input logic [1:0] b, input logic [7:0] p, input logic [15:0] d);
    readwritebank  = b;
    readwriteptr   = p;
    writedataout   = d;
    epc_data_ready = 1'b1;
    tick();
    epc_data_ready = 1'b0;
    tick();
  endtask

  task automatic do_start(input logic m, input logic [1:0] b, input logic [7:0] p,
                          input logic [7:0] w, input logic [15:0] h);
    mode          = m;
    readwritebank = b;
    readwriteptr  = p;
    readwords     = w;
    currenthandle = h;
    start         = 1'b1;
    tick();
    start         = 1'b0;
  endtask

  task automatic do_select(input logic [1:0] b, input logic [7:0] p,
                           input logic [15:0] m, input logic [2:0] a);
    readwritebank = b;
    sel_ptr       = p;
    mask          = m;
    sel_action    = a;
    sel_strobe    = 1'b1;
    tick();
    sel_strobe    = 1'b0;
  endtask

  initial begin
    logic [159:0] s;
    logic         de, da;
    logic [19:0]  epc_top;

    // Reset state
    tick();
    tick();
    check("reset_outputs", 160'({membitsrc, memdatadone, sl_flag, busy}), 160'(4'b0000));
    reset = 1'b0;
    tick();

    // EPC reply: 112 bits of EPC_INIT
    do_start(1'b0, 2'd0, 8'd0, 8'd0, 16'h0000);
    check("epc_busy", 160'(busy), 160'(1'b1));
    run_bits(112, s, de, da);
    check("epc_stream", s, 160'(EPC_INIT));
    check("epc_done_early", 160'(de), 160'(1'b0));
    check("epc_done_after", 160'(da), 160'(1'b1));
    check("epc_busy_after", 160'(busy), 160'(1'b0));
    // Extra edge in DONE is ignored
    run_bits(1, s, de, da);
    check("epc_done_hold", 160'({memdatadone, membitsrc}), 160'(2'b10));

    // WRITE then READ one word with handle
    do_write(2'd3, 8'd2, 16'hBEEF);
    do_start(1'b1, 2'd3, 8'd2, 8'd1, 16'hA5C3);
    check("read_hdr", 160'({busy, membitsrc, memdatadone}), 160'(3'b100));
    run_bits(33, s, de, da);
    check("read1_stream", s, 160'({1'b0, 16'hBEEF, 16'hA5C3}));
    check("read1_done", 160'({de, da}), 160'(2'b01));

    // READ with readwords=0 behaves as one word
    do_start(1'b1, 2'd3, 8'd2, 8'd0, 16'h0F1E);
    run_bits(33, s, de, da);
    check("read0_stream", s, 160'({1'b0, 16'hBEEF, 16'h0F1E}));
    check("read0_done", 160'({de, da}), 160'(2'b01));

    // READ crossing the end of the bank: word 8 reads as zero
    do_write(2'd3, 8'd7, 16'hC0DE);
    do_start(1'b1, 2'd3, 8'd7, 8'd2, 16'h5A5A);
    run_bits(49, s, de, da);
    check("read_oob_stream", s, 160'({1'b0, 16'hC0DE, 16'h0000, 16'h5A5A}));
    check("read_oob_done", 160'({de, da}), 160'(2'b01));

    // SELECT
    do_select(2'd1, 8'd1, 16'h3000, 3'd0);
    check("sel_a0_match", 160'(sl_flag), 160'(1'b1));
    do_select(2'd1, 8'd1, 16'h1111, 3'd0);
    check("sel_a0_nomatch", 160'(sl_flag), 160'(1'b0));
    do_select(2'd1, 8'd1, 16'h3000, 3'd3);
    check("sel_a3_tog1", 160'(sl_flag), 160'(1'b1));
    do_select(2'd1, 8'd1, 16'h3000, 3'd3);
    check("sel_a3_tog2", 160'(sl_flag), 160'(1'b0));
    do_select(2'd1, 8'd9, 16'h0000, 3'd6);
    check("sel_oob_a6", 160'(sl_flag), 160'(1'b1));
    do_select(2'd1, 8'd9, 16'h0000, 3'd0);
    check("sel_oob_a0", 160'(sl_flag), 160'(1'b0));
    do_select(2'd1, 8'd7, 16'h1234, 3'd4);
    check("sel_a4_match", 160'(sl_flag), 160'(1'b0));
    do_select(2'd1, 8'd7, 16'h1235, 3'd7);
    check("sel_a7_nomatch", 160'(sl_flag), 160'(1'b1));

    // start mid-DATA restarts the stream
    do_start(1'b0, 2'd0, 8'd0, 8'd0, 16'h0000);
    run_bits(20, s, de, da);
    epc_top = EPC_INIT[111:92];
    check("restart_prefix", s, 160'(epc_top));
    do_start(1'b1, 2'd3, 8'd2, 8'd1, 16'h1357);
    run_bits(33, s, de, da);
    check("restart_stream", s, 160'({1'b0, 16'hBEEF, 16'h1357}));
    check("restart_done", 160'({de, da}), 160'(2'b01));

    // Reset mid-reply clears outputs and memory
    do_select(2'd1, 8'd1, 16'h3000, 3'd1);
    do_start(1'b0, 2'd0, 8'd0, 8'd0, 16'h0000);
    run_bits(40, s, de, da);
    check("pre_reset", 160'({busy, sl_flag}), 160'(2'b11));
    reset = 1'b1;
    tick();
    check("mid_reset_outputs", 160'({membitsrc, memdatadone, sl_flag, busy}), 160'(4'b0000));
    reset = 1'b0;
    tick();
    do_start(1'b1, 2'd3, 8'd2, 8'd1, 16'h0F0F);
    run_bits(33, s, de, da);
    check("post_reset_read", s, 160'({1'b0, 16'h0000, 16'h0F0F}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tag_memory_serializer.md
Name:
tag_memory_serializer

Overview:
- Tag-side memory and bit-serial data source for the tag top level.
- Holds the four Gen2 banks as 16-bit words and serves the membitclk / membitsrc / memdatadone interface used by the sequencer for EPC replies and READ replies.
- Commits WRITE data presented on writedataout / epc_data_ready.
- Evaluates the SELECT mask match and drives sl_flag back to the controller.

Parameters:
- WORDS_PER_BANK, 8, 16-bit words per bank; valid word addresses are 0..WORDS_PER_BANK-1.
- EPC_WORDS, 7, words sent for an EPC reply: PC word plus EPC words, taken from bank 1 starting at word 1.
- EPC_INIT, 112'h3000_0000_0000_0000_0000_0000_1234, reset contents of bank 1 words 1..7, MSB word first.

Ports:
- clk  in  1  master oscillator clock.
- reset  in  1  synchronous, active-high.
- start  in  1  one-clk pulse; latches mode, bank, ptr and words, then begins serialising.
- mode  in  1  0 = EPC reply; 1 = READ reply.
- readwritebank  in  2  bank for READ, WRITE and SELECT.
- readwriteptr  in  8  word pointer for READ and WRITE.
- readwords  in  8  READ word count; 0 is treated as 1.
- currenthandle  in  16  handle appended to a READ reply.
- membitclk  in  1  tx bit clock, sampled in the clk domain.
- membitsrc  out  1  current serial bit, MSB first.
- memdatadone  out  1  all bits of the reply have been consumed.
- writedataout  in  16  WRITE data word.
- epc_data_ready  in  1  WRITE strobe; acted on at its rising edge.
- sel_strobe  in  1  one-clk pulse; evaluate SELECT.
- sel_action  in  3  Gen2 select action, 0..7.
- sel_ptr  in  8  word address of the mask compare.
- mask  in  16  compare value.
- sl_flag  out  1  SL flag.
- busy  out  1  serialiser is active.

Behaviour:
- Reset: all outputs are 0. FSM goes to IDLE. Bank 1 words 1..7 load EPC_INIT; every other word loads 0.
- Edge detect:
  - mbc_q is a 1-clk registered copy of membitclk.
  - A bit is advanced on every clk cycle where membitclk=1 and mbc_q=0.
  - epc_data_ready uses the same edge detect.
- FSM states: IDLE, HDR, DATA, HANDLE, DONE.
- start, from any state:
  - Latches inputs, loads the bit counter and goes to HDR (mode 1) or DATA (mode 0).
  - The first bit is valid on membitsrc the next clk.
  - memdatadone clears on that same cycle.
- HDR:
  - membitsrc=0.
  - One membitclk edge moves to DATA.
- DATA:
  - membitsrc = shreg[15]; each edge shifts left one bit.
  - After the 16th bit of a word, the next word is loaded at pointer+1. The word count decrements and there is no gap between words.
  - Pointer arithmetic is 8-bit.
  - Any address >= WORDS_PER_BANK reads as 16'h0000.
  - EPC mode uses bank 1, starting at word 1, for EPC_WORDS words.
- After the last data word:
  - mode 1 goes to HANDLE.
  - mode 0 goes to DONE.
- HANDLE:
  - Shifts out currenthandle, sampled at entry to HANDLE, as 16 bits MSB first.
  - Then goes to DONE.
- DONE:
  - memdatadone=1 from the clk after the edge that consumed the final bit.
  - It holds until the next start or reset. Extra edges are ignored.
  - membitsrc=0 in DONE and in IDLE.
- busy = 1 in HDR, DATA and HANDLE.
- Bit totals:
  - READ reply: 1 + 16*max(readwords,1) + 16 bits.
  - EPC reply: 16*EPC_WORDS bits.
- WRITE:
  - On an epc_data_ready rising edge, writes mem[readwritebank][readwriteptr] <= writedataout.
  - The write is ignored if ptr >= WORDS_PER_BANK.
  - Accepted in any state. The word already in shreg is unaffected; later loads see the new data.
- SELECT:
  - On sel_strobe, match = (ptr < WORDS_PER_BANK) && mem[readwritebank][sel_ptr] == mask.
  - Action on match / no match:
    - 0: set / clear.
    - 1: set / nothing.
    - 2: nothing / clear.
    - 3: toggle / nothing.
    - 4: clear / set.
    - 5: clear / nothing.
    - 6: nothing / set.
    - 7: nothing / toggle.
  - sl_flag updates 1 clk after sel_strobe.
- Simultaneous start and sel_strobe: both act. Simultaneous start and write: the write commits first, so the loaded word sees the new data.
- Reset mid-reply: returns to IDLE within one clk and memory is reinitialised.

Decomposition:
- Shared package tag_mem_pkg:
  - Bank codes: RESERVED=0, EPC=1, TID=2, USER=3.
  - FSM state encoding.
  - Select action codes.
  - READ header bit value.
- One sub-module, tag_mem_array: 4 x WORDS_PER_BANK x 16 register array with one combinational read port for the serialiser and a second for the select compare.
- The write port is synchronous. The array takes the EPC_INIT parameter.

Test Plan:
- Reset, start with mode=0, then 112 membitclk edges:
  - bit stream equals EPC_INIT (PC 16'h3000 first).
  - memdatadone rises 1 clk after edge 112.
  - busy is 0 afterwards.
- WRITE bank 3, ptr 2, data 16'hBEEF; then READ bank 3, ptr 2, words 1, handle 16'hA5C3:
  - 33 bits: 0, then BEEF, then A5C3.
  - memdatadone after edge 33.
- READ bank 3, ptr 7, words 2 (WORDS_PER_BANK=8):
  - second word is 16'h0000 (out of range).
  - total 49 bits.
- SELECT bank 1, sel_ptr 1, mask 16'h3000:
  - action 0 gives sl_flag=1.
  - action 0 with mask 16'h1111 then gives sl_flag=0.
  - action 3 with a match toggles 0 to 1 to 0 over two strobes.
- start mid-DATA after 20 edges:
  - stream restarts from the new first bit.
  - memdatadone stays 0 until the new reply completes.
- reset asserted at edge 40 of an EPC reply:
  - all outputs are 0 next clk.
  - the written word from test 2 is restored to 0.
